// File: rtl/gray2bin_serial.sv
// Iterative Gray-to-binary decoder: one binary bit per clock, MSB first,
// with valid/ready handshakes on the input and output sides.
module gray2bin_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary_out,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] bin_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] bit_next;

  // bit_next[i] is the binary bit i once bit i+1 has been resolved.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == WIDTH - 1) begin : g_msb
      assign bit_next[gi] = gray_reg[gi];
    end else begin : g_low
      assign bit_next[gi] = bin_reg[gi+1] ^ gray_reg[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= IDX_MSB;
      gray_reg      <= '0;
      bin_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            gray_reg     <= gray_in;
            idx_reg      <= IDX_MSB;
            state_reg    <= CONV;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        CONV: begin
          bin_reg[idx_reg] <= bit_next[idx_reg];
          if (idx_reg == '0) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          idx_reg       <= IDX_MSB;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = busy_reg;
  assign binary_out = bin_reg;

endmodule

// File: tb/tb_gray2bin_serial.sv
// Self-checking bench for gray2bin_serial: lane 0 is WIDTH=4, lane 1 is WIDTH=8,
// both checked every cycle against a prefix-XOR handshake model.
module tb_gray2bin_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [7:0] gray_in [2];
  wire  [1:0] in_ready;
  wire  [1:0] out_valid;
  wire  [1:0] busy;
  wire  [3:0] bo4;
  wire  [7:0] bo8;

  int tests = 0;
  int fails = 0;

  gray2bin_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .gray_in(gray_in[0][3:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .binary_out(bo4),
    .busy(busy[0])
  );

  gray2bin_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .gray_in(gray_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .binary_out(bo8),
    .busy(busy[1])
  );

  function automatic int wid(input int l);
    return (l == 0) ? 4 : 8;
  endfunction

  function automatic logic [7:0] mask(input int l);
    return (l == 0) ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic [7:0] bo(input int l);
    return (l == 0) ? {4'b0000, bo4} : bo8;
  endfunction

  // Binary bit i is the XOR of all Gray bits from i upward.
  function automatic logic [7:0] g2b(input logic [7:0] g, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      for (int j = i; j < w; j++)
        r[i] = r[i] ^ g[j];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 = waiting for a word, 1 = decoding, 2 = holding a result.
  int         m_phase [2];
  int         m_left  [2];
  logic [7:0] m_res   [2];
  bit         m_armed [2];

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_phase[l] = 0;
      m_left[l]  = 0;
      m_res[l]   = '0;
      m_armed[l] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        m_phase[l] = 0;
        m_armed[l] = 1'b1;
      end else if (m_phase[l] == 0) begin
        if (in_valid[l]) begin
          m_res[l]   = g2b(gray_in[l] & mask(l), wid(l));
          m_left[l]  = wid(l);
          m_phase[l] = 1;
        end
      end else if (m_phase[l] == 1) begin
        m_left[l] = m_left[l] - 1;
        if (m_left[l] == 0) m_phase[l] = 2;
      end else if (out_ready[l]) begin
        m_phase[l] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (m_armed[l]) begin
        check($sformatf("cyc_in_ready_l%0d", l), 32'(in_ready[l]), 32'(m_phase[l] == 0));
        check($sformatf("cyc_out_valid_l%0d", l), 32'(out_valid[l]), 32'(m_phase[l] == 2));
        check($sformatf("cyc_busy_l%0d", l), 32'(busy[l]), 32'(m_phase[l] != 0));
        if (m_phase[l] == 2)
          check($sformatf("cyc_data_l%0d", l), 32'(bo(l)), 32'(m_res[l]));
      end
    end
  end

  task automatic wait_ready(input int l);
    int n = 0;
    while (in_ready[l] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("wait_in_ready_l%0d", l), 32'(in_ready[l]), 32'd1);
  endtask

  task automatic run_word(input int l, input logic [7:0] g, input logic [7:0] expb,
                          input int stall, input bit poke, input string tag);
    int n;
    logic [7:0] held;
    wait_ready(l);
    in_valid[l]  = 1'b1;
    gray_in[l]   = g;
    out_ready[l] = (stall == 0);
    @(posedge clk); #1;
    in_valid[l] = poke;
    gray_in[l]  = poke ? 8'hFF : 8'($urandom);
    n = 0;
    while (out_valid[l] !== 1'b1 && n < 40) begin
      if (poke) check({tag, "_in_ready_low"}, 32'(in_ready[l]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    in_valid[l] = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(wid(l)));
    check({tag, "_data"}, 32'(bo(l)), 32'(expb));
    held = bo(l);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid[l]), 32'd1);
      check({tag, "_hold_data"}, 32'(bo(l)), 32'(held));
    end
    out_ready[l] = 1'b1;
    @(posedge clk); #1;
    check({tag, "_post_valid"}, 32'(out_valid[l]), 32'd0);
    check({tag, "_post_ready"}, 32'(in_ready[l]), 32'd1);
    $display("[TB] lane%0d %s gray=%0h bin=%0h stall=%0d", l, tag, g, held, stall);
  endtask

  initial begin
    logic [7:0] g;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    gray_in[0] = '0;
    gray_in[1] = '0;

    check("model_0110", 32'(g2b(8'h06, 4)), 32'h4);
    check("model_1110", 32'(g2b(8'h0E, 4)), 32'hB);
    check("model_1000", 32'(g2b(8'h08, 4)), 32'hF);
    check("model_w8_msb", 32'(g2b(8'h80, 8)), 32'hFF);

    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("rst_in_ready_l%0d", l), 32'(in_ready[l]), 32'd1);
      check($sformatf("rst_out_valid_l%0d", l), 32'(out_valid[l]), 32'd0);
      check($sformatf("rst_busy_l%0d", l), 32'(busy[l]), 32'd0);
      check($sformatf("rst_data_l%0d", l), 32'(bo(l)), 32'd0);
    end
    rst = 1'b0;

    run_word(0, 8'b0110, 8'b0100, 0, 1'b0, "dir");
    run_word(0, 8'b1110, 8'b1011, 0, 1'b0, "dir");
    run_word(0, 8'b1000, 8'b1111, 0, 1'b0, "dir");
    run_word(0, 8'b0000, 8'b0000, 0, 1'b0, "dir");
    run_word(0, 8'b1110, 8'b1011, 5, 1'b0, "backpressure");
    run_word(0, 8'b0110, 8'b0100, 0, 1'b1, "busy_reject");

    // Abort a word two cycles into decoding.
    wait_ready(0);
    in_valid[0] = 1'b1;
    gray_in[0]  = 8'b0010;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_output", 32'(out_valid[0]), 32'd0);
    end
    $display("[TB] lane0 mid-conversion reset done");
    run_word(0, 8'b0110, 8'b0100, 0, 1'b0, "after_rst");

    for (int b = 0; b < 16; b++)
      run_word(0, 8'(b ^ (b >> 1)), 8'(b), int'($urandom_range(0, 3)), 1'b0, "sweep4");
    for (int b = 0; b < 256; b++)
      run_word(1, 8'(b ^ (b >> 1)), 8'(b), int'($urandom_range(0, 2)), 1'b0, "sweep8");

    for (int i = 0; i < 30; i++) begin
      g = 8'($urandom) & 8'h0F;
      run_word(0, g, g2b(g, 4), int'($urandom_range(0, 3)), 1'($urandom), "rand4");
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
